adc_sample_fifo: RTL

//  Downstream consumer of the SPI ADC front end. Captures each 16-bit sample on its drdy strobe.

---
 rtl/adc_sample_fifo.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_fifo.sv
// -----------------------------------------------------------------------------
// adc_sample_fifo
// Captures 16-bit ADC samples on drdy, optionally box-car averages them,
// buffers the results in a circular FIFO and serialises each word MSB-first
// as two bytes over a valid/ready handshake.
//
// Optional feature macro: ADC_SAMPLE_AVG_EN
//   defined   -> 2^AVG_LOG2 captured samples are averaged into one write word
//   undefined -> every captured sample is a write word, AVG_LOG2 unused
//
// Ports
//   clk       in   system clock, rising edge
//   res       in   synchronous active-high reset
//   en        in   capture enable (low also clears the averager)
//   drdy      in   one-cycle sample strobe
//   din       in   16-bit unsigned sample
//   tx_data   out  byte being offered
//   tx_valid  out  tx_data valid
//   tx_ready  in   consumer accepts byte on tx_valid & tx_ready
//   level     out  words held in the FIFO (not counting the serialiser word)
//   ovf       out  sticky overflow flag
//   ovf_clr   in   clears ovf and drop_cnt
//   drop_cnt  out  dropped-word count, saturating at 255
// -----------------------------------------------------------------------------
module adc_sample_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  en,
    input  logic                  drdy,
    input  logic [15:0]           din,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

    logic [15:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [15:0]           r_hold;
    logic                  r_ovf;
    logic [7:0]            r_drop_cnt;
    state_t                r_state;
    state_t                w_next_state;

    logic                  w_word_valid;
    logic [15:0]           w_word;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;

`ifdef ADC_SAMPLE_AVG_EN
    localparam int unsigned ACC_W = 16 + AVG_LOG2;

    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [ACC_W-1:0]    w_sum;
    logic                w_last;

    assign w_sum        = r_acc + ACC_W'(din);
    assign w_last       = (r_cnt == {AVG_LOG2{1'b1}});
    assign w_word_valid = drdy & en & w_last;
    // Truncating divide by 2^AVG_LOG2: keep the top 16 bits of the sum.
    assign w_word       = w_sum[ACC_W-1:AVG_LOG2];

    // Accumulator: partial sums are discarded whenever capture is disabled.
    always_ff @(posedge clk) begin
        if (res || !en) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (drdy) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + AVG_LOG2'(1);
            end
        end
    end
`else
    logic w_unused_avg;

    assign w_unused_avg = &{1'b0, 32'(AVG_LOG2)};
    assign w_word_valid = drdy & en;
    assign w_word       = din;
`endif

    // Full is judged on the registered level; a same-cycle pop does not free a slot.
    assign w_full = (r_level == LVL_W'(DEPTH));
    assign w_push = w_word_valid & ~w_full;
    assign w_drop = w_word_valid &  w_full;
    assign w_pop  = (r_state == S_IDLE) && (r_level != '0);

    // FIFO storage needs no reset; only pointers and level define contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers, level and serialiser holding register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Overflow bookkeeping; a drop in the same cycle as ovf_clr wins.
    always_ff @(posedge clk) begin
        if (res) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    // Serialiser state register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Serialiser next state: IDLE -> HI -> LO -> IDLE, advancing on handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (r_level != '0) w_next_state = S_HI;
            S_HI:    if (tx_ready)      w_next_state = S_LO;
            S_LO:    if (tx_ready)      w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Serialiser outputs decoded from the registered state and hold word.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (r_state)
            S_HI: begin
                tx_valid = 1'b1;
                tx_data  = r_hold[15:8];
            end
            S_LO: begin
                tx_valid = 1'b1;
                tx_data  = r_hold[7:0];
            end
            default: ;
        endcase
    end

    assign level    = r_level;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule
